// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3/funct7 decode values, FSM state encodings and the iteration count.
package muldiv_pkg;

    localparam logic [2:0] FNC3_MUL    = 3'b000;
    localparam logic [2:0] FNC3_MULH   = 3'b001;
    localparam logic [2:0] FNC3_MULHSU = 3'b010;
    localparam logic [2:0] FNC3_MULHU  = 3'b011;
    localparam logic [2:0] FNC3_DIV    = 3'b100;
    localparam logic [2:0] FNC3_DIVU   = 3'b101;
    localparam logic [2:0] FNC3_REM    = 3'b110;
    localparam logic [2:0] FNC3_REMU   = 3'b111;

    localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    localparam int MD_ITERS = 32;

    // funct3[2] clear means a multiply-family op.
    function automatic logic md_is_mul(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational result stage for muldiv_unit: applies the recorded sign to
// the magnitude result, selects the product half / quotient / remainder,
// and substitutes the divide-by-zero, signed-overflow and zero-multiply
// special-case results.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic              neg,
    input  logic              div_zero,
    input  logic              div_ovf,
    input  logic              mul_zero,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    input  logic [XLEN-1:0]   a_raw,
    output logic [XLEN-1:0]   res
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Sign restoration followed by the per-op result select.
    always_comb begin
        prod_fix = neg ? (~prod + 1'b1) : prod;
        quo_fix  = neg ? (~quo + 1'b1)  : quo;
        rem_fix  = neg ? (~rem + 1'b1)  : rem;
        res      = '0;
        case (op)
            FNC3_MUL:
                res = mul_zero ? '0 : prod_fix[XLEN-1:0];
            FNC3_MULH, FNC3_MULHSU, FNC3_MULHU:
                res = mul_zero ? '0 : prod_fix[2*XLEN-1:XLEN];
            FNC3_DIV, FNC3_DIVU: begin
                if (div_zero)     res = '1;
                else if (div_ovf) res = XMIN;
                else              res = quo_fix;
            end
            default: begin
                if (div_zero)     res = a_raw;
                else if (div_ovf) res = '0;
                else              res = rem_fix;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (execute stage).
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// 32 CALC iterations, one FIX cycle for sign/special-case correction,
// then a one-cycle DONE pulse. busy stalls the front of the pipe.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-multiply, divide-by-zero
// and signed-overflow ops skip CALC/FIX and complete in DONE one cycle
// after accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_ITERS - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [1:0]        launch_state;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              dz_q;
    logic              ovf_q;
    logic              mz_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [XLEN-1:0]   mplier_q;   // multiplier, or dividend shifting into quotient
    logic [2*XLEN-1:0] mcand_q;    // shifting multiplicand, or divisor in low word
    logic [2*XLEN-1:0] acc_q;      // product, or partial remainder in [XLEN:0]
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   fix_res;

    logic              accept;
    logic              go_early;
    logic              sa;
    logic              sb;
    logic              neg_in;
    logic              dz_in;
    logic              ovf_in;
    logic              mz_in;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    assign accept = start & ~kill & ((state_q == MD_IDLE) | (state_q == MD_DONE));

    // Operand signedness, magnitudes, result sign and special-case flags at accept.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (funct3)
            FNC3_MULH, FNC3_DIV, FNC3_REM: begin
                sa = a[XLEN-1];
                sb = b[XLEN-1];
            end
            FNC3_MULHSU: sa = a[XLEN-1];
            default: ;
        endcase
        abs_a  = sa ? (~a + 1'b1) : a;
        abs_b  = sb ? (~b + 1'b1) : b;
        neg_in = (funct3 == FNC3_REM) ? sa : (sa ^ sb);
        dz_in  = ~md_is_mul(funct3) & (b == '0);
        ovf_in = ((funct3 == FNC3_DIV) | (funct3 == FNC3_REM)) & (a == XMIN) & (b == '1);
        mz_in  = md_is_mul(funct3) & ((a == '0) | (b == '0));
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic special_in;
    logic early_q;
    assign special_in = mz_in | dz_in | ovf_in;
    assign go_early   = special_in;
`else
    assign go_early   = 1'b0;
`endif

    assign launch_state = go_early ? MD_DONE : MD_CALC;

    // Next-state logic; kill aborts CALC/FIX and suppresses launch from IDLE/DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = launch_state;
            MD_CALC: begin
                if (kill)               state_d = MD_IDLE;
                else if (cnt_q == LAST) state_d = MD_FIX;
            end
            MD_FIX:  state_d = kill ? MD_IDLE : MD_DONE;
            MD_DONE: state_d = accept ? launch_state : MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // One restoring-divide step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        div_shift = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    end

    // Operand latch at accept and one shift-add / restoring-divide step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            mz_q     <= 1'b0;
            a_raw_q  <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= funct3;
            neg_q    <= neg_in;
            dz_q     <= dz_in;
            ovf_q    <= ovf_in;
            mz_q     <= mz_in;
            a_raw_q  <= a;
            acc_q    <= '0;
            if (md_is_mul(funct3)) begin
                mcand_q  <= {{XLEN{1'b0}}, abs_a};
                mplier_q <= abs_b;
            end else begin
                mcand_q  <= {{XLEN{1'b0}}, abs_b};
                mplier_q <= abs_a;
            end
        end else if (state_q == MD_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (md_is_mul(op_q)) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end else begin
                if (!div_diff[XLEN]) acc_q[XLEN:0] <= div_diff;
                else                 acc_q[XLEN:0] <= div_shift;
                mplier_q <= {mplier_q[XLEN-2:0], ~div_diff[XLEN]};
            end
        end
    end

    muldiv_fixup #(.XLEN(XLEN)) u_fixup (
        .op       (op_q),
        .neg      (neg_q),
        .div_zero (dz_q),
        .div_ovf  (ovf_q),
        .mul_zero (mz_q),
        .prod     (acc_q),
        .quo      (mplier_q),
        .rem      (acc_q[XLEN-1:0]),
        .a_raw    (a_raw_q),
        .res      (fix_res)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Remember whether the op in flight took the early-out path.
    always_ff @(posedge clk) begin
        if (rst)         early_q <= 1'b0;
        else if (accept) early_q <= special_in;
    end

    // Result register: loaded at the FIX edge, or on leaving an early-out DONE.
    always_ff @(posedge clk) begin
        if (rst)                                result_q <= '0;
        else if (state_q == MD_FIX && !kill)    result_q <= fix_res;
        else if (state_q == MD_DONE && early_q) result_q <= fix_res;
    end

    assign result = (state_q == MD_DONE && early_q) ? fix_res : result_q;
`else
    // Result register: loaded only at the FIX edge, held otherwise.
    always_ff @(posedge clk) begin
        if (rst)                             result_q <= '0;
        else if (state_q == MD_FIX && !kill) result_q <= fix_res;
    end

    assign result = result_q;
`endif

    assign busy = (state_q == MD_CALC) | (state_q == MD_FIX);
    assign done = (state_q == MD_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an RV32M arithmetic reference plus a
// cycle-count model of busy/done/result, compared every cycle, with directed
// test-plan cases and a randomized phase.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M results straight from the ISA definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy, p;
        logic [63:0] pu;
        int          ix, iy;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = int'(x);
        iy = int'(y);
        case (f3)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Cycles from accept to the done pulse.
    function automatic int lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        bit special;
        if (!f3[2]) special = (x == 0) || (y == 0);
        else special = (y == 0) ||
                       ((f3 == 3'd4 || f3 == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF);
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Model: t = cycles since accept (0 = nothing in flight), L = this op's latency.
    int          t = 0;
    int          L = 34;
    logic [31:0] pend = '0;
    logic [31:0] mres = '0;
    bit          model_on = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            t    = 0;
            mres = '0;
        end else begin
            if (t >= 1 && t < L) begin
                if (kill) t = 0;
                else      t++;
            end else if (start && !kill) begin
                t    = 1;
                L    = lat(funct3, a, b);
                pend = ref_op(funct3, a, b);
            end else begin
                t = 0;
            end
            if (t != 0 && t == L) mres = pend;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("busy", 32'(busy), 32'(t >= 1 && t < L));
            check("done", 32'(done), 32'(t >= 1 && t == L));
            check("result", result, mres);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int n;
        start  = 1'b1;
        funct3 = f3;
        a      = x;
        b      = y;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " result"}, result, exp);
        check({name, " latency"}, 32'(n), 32'(lat(f3, x, y)));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int dones;
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        model_on = 1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pin the reference against hand-computed values.
        check("pin MUL", ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        check("pin MULHSU", ref_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        check("pin REM", ref_op(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        run_op("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("MULH", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_op("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_op("REMU", 3'd7, 32'hFFFFFFFF, 32'd16, 32'h0000000F);
        run_op("DIV0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op("REM0", 3'd6, 32'd5, 32'd0, 32'd5);
        run_op("REMneg0", 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
        run_op("DIVU0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op("DIVovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("REMovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        run_op("MULzero", 3'd1, 32'h0, 32'h12345678, 32'h0);
        run_op("DIVU", 3'd5, 32'd7, 32'd2, 32'd3);

        // kill in CALC at cycle 10.
        start = 1'b1; funct3 = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 32'(busy), 32'd0);
        check("kill result", result, 32'd3);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done) dones++; end
        check("kill no done", 32'(dones), 32'd0);

        // rst at cycle 20 of another op.
        start = 1'b1; funct3 = 3'd6; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst result", result, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done) dones++; end
        check("rst no done", 32'(dones), 32'd0);

        // start pulsed during CALC is ignored.
        start = 1'b1; funct3 = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'd5; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        repeat (80) begin @(negedge clk); if (done) dones++; end
        check("busy start single done", 32'(dones), 32'd1);
        check("busy start result", result, 32'd42);

        // start held high through DONE: back-to-back launch.
        start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd5;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 200);
        check("b2b first done cycle", 32'(n), 32'd34);
        check("b2b first result", result, 32'd15);
        funct3 = 3'd5; a = 32'd100; b = 32'd7;
        do begin
            @(negedge clk); n++;
            if (n == 50) check("b2b hold result", result, 32'd15);
        end while (!done && n < 200);
        start = 1'b0;
        check("b2b second done cycle", 32'(n), 32'd68);
        check("b2b second result", result, 32'd14);
        @(negedge clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            start  = ($urandom % 6) == 0;
            kill   = ($urandom % 80) == 0;
            rst    = ($urandom % 1500) == 0;
            funct3 = 3'($urandom);
            a      = pick();
            b      = pick();
            @(negedge clk);
        end
        start = 1'b0; kill = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
